i2s_adc_rx: RTL and testbench
=============================

# i2s_adc_rx

Audio-codec ADC receiver. It deserialises the WM8731 I2S ADC stream (BCLK/ADCLRCK/ADCDAT) into 24-bit signed left/right samples and a derived mono sample, all in the system `clk` domain. It sits directly upstream of the moving-average low-pass filter: `mono_data` is that filter's `data_in`, and `sample_valid` is its per-sample advance.

## Interface
- `DATA_WIDTH`, default 24: bits per channel word, MSB first.
- `SYNC_STAGES`, default 2: synchroniser flops on each codec input, minimum 2.
- `clk` in 1: system clock. It must be at least 4× the `aud_bclk` frequency.
- `rst_n` in 1: asynchronous, active-low reset. It asserts immediately and is released synchronously to `clk` by the top level.
- `aud_bclk` in 1: codec bit clock, asynchronous to `clk`.
- `aud_adclrck` in 1: codec frame clock, asynchronous. Low = left channel, high = right channel.
- `aud_adcdat` in 1: codec serial data, asynchronous.
- `sample_ready` in 1: consumer accepts the pair. Tie it high when feeding the low-pass filter.
- `sample_valid` out 1: a left/right pair is held on the outputs.
- `left_data` out DATA_WIDTH: signed left sample.
- `right_data` out DATA_WIDTH: signed right sample.
- `mono_data` out DATA_WIDTH: (left+right) arithmetic-shifted right by 1.
- `overrun` out 1: sticky flag. A completed pair was dropped because the output slot was full.
- `frame_err_cnt` out 8: number of short frames. Saturates at 255.

## Operation
- **Input conditioning.** All three codec inputs pass through `SYNC_STAGES` flops. A further register holds the previous synchronised `bclk` and `lrck`.
  - `bclk_rise` = synchronised `bclk` high and previous `bclk` low.
  - `lrck_edge` = synchronised `lrck` differs from previous `lrck`, qualified by `bclk_rise`.
- **FSM states:**
  - `HUNT`: after reset, ignore data until the first `lrck_edge`.
  - `SKIP`: I2S one-bit delay. The next `bclk_rise` is discarded; go to `SHIFT`.
  - `SHIFT`: each `bclk_rise` shifts `adcdat` into the LSB of the shift register and increments the bit counter. At count == DATA_WIDTH, latch the word into the channel selected by the `lrck` level captured at the frame edge, then go to `PAD`.
  - `PAD`: ignore remaining BCLKs until `lrck_edge`, then go to `SKIP`.
- **Short frame.** An `lrck_edge` while in `SHIFT` with count < DATA_WIDTH:
  - discard the partial word;
  - increment `frame_err_cnt` (saturating);
  - go to `SKIP`, which resynchronises on that edge.
- **Pair completion.** Completion occurs when the right word latches and a left word was latched earlier in the same L→R frame. A right word with no preceding left word (first frame after `HUNT`) is discarded silently.
- **Output slot (one deep):**
  - On completion with the slot empty or being accepted this cycle: load `left_data`/`right_data`/`mono_data` and set `sample_valid`.
  - On completion with `sample_valid`=1 and `sample_ready`=0: keep the old pair and set `overrun`, which stays set until reset.
  - `sample_valid` clears on the cycle after `sample_valid`&`sample_ready` unless a new pair loads in that same cycle.
- **Mono arithmetic.** Sign-extend both words to DATA_WIDTH+1 bits, add, then arithmetic-shift right 1 and truncate to DATA_WIDTH. This rounds toward −∞ and never overflows.
- **Reset values.** `sample_valid`=0, data outputs=0, `overrun`=0, `frame_err_cnt`=0, FSM=`HUNT`, bit counter=0, synchronisers=0.
  - Reset mid-frame abandons the frame; the block re-hunts.

## Timing
- **Latency.** Let N be the first `clk` cycle in which the raw `aud_bclk` rise is sampled by synchroniser stage 1.
  - `bclk_rise` is seen in cycle N+SYNC_STAGES.
  - The final right-channel bit is shifted at the end of that cycle.
  - `sample_valid` and data are registered and visible in cycle N+SYNC_STAGES+1, which is N+3 at default.
- **Outputs.** All outputs are registered. `mono_data` changes only in the same cycle as `left_data`/`right_data`.
- **Throughput.** One pair per LRCK period. The consumer must accept within one LRCK period or `overrun` is set.
- **Simultaneous events.**
  - `lrck_edge` and count reaching DATA_WIDTH on the same `bclk_rise`: this cannot occur, because the edge is qualified before the shift. If the count was already DATA_WIDTH the word was latched earlier and the frame is good.
  - Accept and new completion in the same cycle: the new pair loads, `sample_valid` stays 1, and `overrun` is not set.

## Structure
- The shared package `audio_pkg` holds:
  - `AUDIO_W` = 24;
  - `typedef logic signed [AUDIO_W-1:0] sample_t`;
  - the FSM enum `i2s_state_t` {HUNT, SKIP, SHIFT, PAD}.
- One sub-module, `sync_edge`: a parameterised SYNC_STAGES synchroniser with registered previous value and rise/any-edge outputs, instantiated for `bclk`, `lrck` and `dat`.

## Test plan
- **Basic pair.** BCLK = clk/8, left 24'h123456, right 24'hABCDEF, ready=1.
  - `left_data`=123456, `right_data`=ABCDEF, `mono_data`=24'hDF0122.
  - `sample_valid` is high for exactly 1 cycle, N+3 after the last right bit.
- **Rounding.** Left 24'h000001, right 24'h000000 → `mono_data`=0. Left 24'hFFFFFF, right 0 → `mono_data`=24'hFFFFFF (−1, floor).
- **Short frame.** LRCK toggles after 10 left bits.
  - No valid, `frame_err_cnt`=1.
  - The following full frame (7FFFFF / 800000) outputs correctly with `mono_data`=24'hFFFFFF.
- **Backpressure.** `sample_ready`=0 across two complete frames.
  - The first pair stays on the outputs and `overrun`=1.
  - Raising ready then shows the first pair is accepted; the second is lost.
- **Start-up.** Stream starts in a right-channel half.
  - No `sample_valid` until the first complete L→R frame.
  - `frame_err_cnt` stays 0.
- **Reset mid-frame.** `rst_n` pulses low for 1 cycle while 12 bits are shifted.
  - Outputs go to 0 asynchronously.
  - The next complete frame after the re-hunt produces the correct pair.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample type, width and I2S receiver state encoding
package audio_pkg;

  localparam int AUDIO_W = 24;

  typedef logic signed [AUDIO_W-1:0] sample_t;

  typedef enum logic [1:0] {
    HUNT,
    SKIP,
    SHIFT,
    PAD
  } i2s_state_t;

endpackage

// File: rtl/i2s_adc_rx_if.sv
// rtl/i2s_adc_rx_if.sv - one-deep left/right/mono sample handshake between receiver and consumer
interface i2s_adc_rx_if
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = AUDIO_W
);

  logic                         sample_valid;
  logic                         sample_ready;
  logic signed [DATA_WIDTH-1:0] left_data;
  logic signed [DATA_WIDTH-1:0] right_data;
  logic signed [DATA_WIDTH-1:0] mono_data;

  modport master (
    output sample_valid,
    output left_data,
    output right_data,
    output mono_data,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  left_data,
    input  right_data,
    input  mono_data,
    output sample_ready
  );

endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchroniser with an enable-gated previous-value register
// and rise / any-edge outputs relative to that previous value.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic en,
  output logic level,
  output logic rise,
  output logic edge_any
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // prev_q only advances when en is high, so a slow strobe can compare
  // against the value seen at its own previous occurrence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      if (en) begin
        prev_q <= sync_q[STAGES-1];
      end
    end
  end

  assign level    = sync_q[STAGES-1];
  assign rise     = level & ~prev_q;
  assign edge_any = level ^ prev_q;

endmodule

// File: rtl/i2s_adc_rx.sv
// rtl/i2s_adc_rx.sv - WM8731 I2S ADC deserialiser producing signed left/right/mono
// sample pairs in the clk domain through a one-deep output slot.
module i2s_adc_rx
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = AUDIO_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 aud_bclk,
  input  logic                 aud_adclrck,
  input  logic                 aud_adcdat,
  i2s_adc_rx_if.master         smp,
  output logic                 overrun,
  output logic [7:0]           frame_err_cnt
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic bclk_rise;
  logic bclk_level_unused;
  logic bclk_edge_unused;
  logic lrck_level;
  logic lrck_diff;
  logic lrck_rise_unused;
  logic dat_level;
  logic dat_rise_unused;
  logic dat_edge_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_bclk (
    .clk(clk), .rst_n(rst_n), .din(aud_bclk), .en(1'b1),
    .level(bclk_level_unused), .rise(bclk_rise), .edge_any(bclk_edge_unused)
  );

  // LRCK history is sampled per BCLK rise, so a frame edge is one that
  // differs from the level seen at the previous bit.
  sync_edge #(.STAGES(SYNC_STAGES)) u_lrck (
    .clk(clk), .rst_n(rst_n), .din(aud_adclrck), .en(bclk_rise),
    .level(lrck_level), .rise(lrck_rise_unused), .edge_any(lrck_diff)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_dat (
    .clk(clk), .rst_n(rst_n), .din(aud_adcdat), .en(1'b1),
    .level(dat_level), .rise(dat_rise_unused), .edge_any(dat_edge_unused)
  );

  i2s_state_t            state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] left_hold;
  logic                  chan_right;
  logic                  have_left;

  logic                  lrck_edge;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  word_done;
  logic                  pair_done;
  logic [DATA_WIDTH:0]   mono_sum;
  logic                  accept;

  always_comb begin
    lrck_edge = bclk_rise & lrck_diff;
    word_next = {shreg[DATA_WIDTH-2:0], dat_level};
    word_done = (state == SHIFT) && bclk_rise && !lrck_edge
                && (bit_cnt == CW'(DATA_WIDTH - 1));
    pair_done = word_done && chan_right && have_left;
    // One guard bit makes the sum exact; dropping the LSB floors toward -inf.
    mono_sum  = {left_hold[DATA_WIDTH-1], left_hold}
              + {word_next[DATA_WIDTH-1], word_next};
    accept    = smp.sample_valid & smp.sample_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= HUNT;
      bit_cnt          <= '0;
      shreg            <= '0;
      left_hold        <= '0;
      chan_right       <= 1'b0;
      have_left        <= 1'b0;
      smp.sample_valid <= 1'b0;
      smp.left_data    <= '0;
      smp.right_data   <= '0;
      smp.mono_data    <= '0;
      overrun          <= 1'b0;
      frame_err_cnt    <= '0;
    end else begin
      if (pair_done) begin
        if (!smp.sample_valid || smp.sample_ready) begin
          smp.sample_valid <= 1'b1;
          smp.left_data    <= left_hold;
          smp.right_data   <= word_next;
          smp.mono_data    <= mono_sum[DATA_WIDTH:1];
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        smp.sample_valid <= 1'b0;
      end

      case (state)
        HUNT: begin
          if (lrck_edge) begin
            state      <= SKIP;
            chan_right <= lrck_level;
            have_left  <= 1'b0;
          end
        end
        SKIP: begin
          if (lrck_edge) begin
            chan_right <= lrck_level;
            if (!lrck_level) have_left <= 1'b0;
          end else if (bclk_rise) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (lrck_edge) begin
            if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
            state      <= SKIP;
            chan_right <= lrck_level;
            have_left  <= 1'b0;
            bit_cnt    <= '0;
          end else if (bclk_rise) begin
            shreg <= word_next;
            if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
              bit_cnt <= CW'(DATA_WIDTH);
              state   <= PAD;
              if (!chan_right) begin
                left_hold <= word_next;
                have_left <= 1'b1;
              end else begin
                have_left <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PAD: begin
          if (lrck_edge) begin
            state      <= SKIP;
            chan_right <= lrck_level;
            if (!lrck_level) have_left <= 1'b0;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb/tb_i2s_adc_rx.sv - table-driven and scoreboarded bench for i2s_adc_rx
module tb_i2s_adc_rx;
  import audio_pkg::*;

  localparam int DW        = AUDIO_W;
  localparam int SLOTS     = 32;
  localparam int HALF_BCLK = 40;
  localparam int NVEC      = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       bclk  = 1'b0;
  logic       lrck  = 1'b0;
  logic       dat   = 1'b0;
  logic       overrun;
  logic [7:0] frame_err_cnt;

  i2s_adc_rx_if #(.DATA_WIDTH(DW)) smp ();

  always #5 clk = ~clk;

  i2s_adc_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .aud_bclk(bclk), .aud_adclrck(lrck),
    .aud_adcdat(dat), .smp(smp), .overrun(overrun), .frame_err_cnt(frame_err_cnt)
  );

  typedef struct {
    sample_t left;
    sample_t right;
    sample_t mono;
  } pair_t;

  pair_t exp_q[$];
  pair_t vec[NVEC];
  pair_t mon_e;
  int    checks  = 0;
  int    errors  = 0;
  int    accepts = 0;
  int    lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && smp.sample_valid && smp.sample_ready) begin
      accepts++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair: got L=%h R=%h expected none", smp.left_data, smp.right_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("left_data", smp.left_data, mon_e.left);
        check("right_data", smp.right_data, mon_e.right);
        check("mono_data", smp.mono_data, mon_e.mono);
      end
    end
  end

  task automatic send_bit(input logic lr, input logic b);
    bclk = 1'b0;
    lrck = lr;
    dat  = b;
    #HALF_BCLK;
    bclk = 1'b1;
    #HALF_BCLK;
  endtask

  function automatic logic slot_bit(input sample_t w, input int s);
    return (s >= 2 && s < 2 + DW) ? w[DW + 1 - s] : 1'b0;
  endfunction

  task automatic send_chan(input logic lr, input sample_t w, input int nslots);
    for (int s = 0; s < nslots; s++) send_bit(lr, slot_bit(w, s));
  endtask

  task automatic send_pair(input sample_t l, input sample_t r);
    send_chan(1'b0, l, SLOTS);
    send_chan(1'b1, r, SLOTS);
  endtask

  // Measures posedges from the last right-bit BCLK rise to sample_valid.
  task automatic send_pair_timed(input sample_t l, input sample_t r, output int latency);
    send_chan(1'b0, l, SLOTS);
    for (int s = 0; s < DW + 1; s++) send_bit(1'b1, slot_bit(r, s));
    bclk = 1'b0;
    lrck = 1'b1;
    dat  = slot_bit(r, DW + 1);
    #HALF_BCLK;
    bclk = 1'b1;
    latency = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (smp.sample_valid && latency < 0) latency = k;
    end
    for (int s = DW + 2; s < SLOTS; s++) send_bit(1'b1, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec[0] = '{24'h123456, 24'hABCDEF, 24'hDF0122};
    vec[1] = '{24'h000001, 24'h000000, 24'h000000};
    vec[2] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF};
    vec[3] = '{24'h7FFFFF, 24'h800000, 24'hFFFFFF};
    vec[4] = '{24'h400000, 24'h400000, 24'h400000};
    vec[5] = '{24'h800000, 24'h800000, 24'h800000};
    vec[6] = '{24'h000003, 24'h000001, 24'h000002};
    vec[7] = '{24'hFFFFFE, 24'hFFFFFF, 24'hFFFFFE};

    smp.sample_ready = 1'b1;
    #2;
    repeat (3) @(negedge clk);
    check("rst_valid", smp.sample_valid, 0);
    check("rst_left", smp.left_data, 0);
    check("rst_mono", smp.mono_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_err_cnt", frame_err_cnt, 0);
    rst_n = 1'b1;

    // Start-up inside a right half: that word must be dropped silently.
    send_chan(1'b1, 24'h0F0F0F, SLOTS);
    check("startup_err_cnt", frame_err_cnt, 0);
    check("startup_no_pair", accepts, 0);

    for (int i = 0; i < NVEC; i++) begin
      exp_q.push_back(vec[i]);
      if (i == 0) begin
        send_pair_timed(vec[i].left, vec[i].right, lat);
        check("latency_cycles", lat, 3);
      end else begin
        send_pair(vec[i].left, vec[i].right);
      end
    end
    repeat (20) @(negedge clk);
    check("table_accepts", accepts, NVEC);
    check("table_err_cnt", frame_err_cnt, 0);

    // Backpressure: two frames with ready low, only the first survives.
    @(posedge clk); #1;
    smp.sample_ready = 1'b0;
    exp_q.push_back('{24'h111111, 24'h222222, 24'h199999});
    send_pair(24'h111111, 24'h222222);
    send_pair(24'h345678, 24'h000000);
    check("bp_valid", smp.sample_valid, 1);
    check("bp_left_held", smp.left_data, 24'h111111);
    check("bp_right_held", smp.right_data, 24'h222222);
    check("bp_overrun", overrun, 1);
    @(posedge clk); #1;
    smp.sample_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("bp_valid_cleared", smp.sample_valid, 0);
    check("bp_queue_empty", exp_q.size(), 0);
    check("bp_overrun_sticky", overrun, 1);

    // Short left frame (10 bits) followed by a full good frame.
    send_chan(1'b0, 24'hFFFFFF, 12);
    send_chan(1'b1, 24'h00AAAA, SLOTS);
    check("short_err_cnt", frame_err_cnt, 1);
    exp_q.push_back('{24'h7FFFFF, 24'h800000, 24'hFFFFFF});
    send_pair(24'h7FFFFF, 24'h800000);
    repeat (4) @(negedge clk);
    check("short_queue_empty", exp_q.size(), 0);

    // Reset pulse after 12 left bits have been shifted.
    fork
      begin
        send_chan(1'b0, 24'h13579B, SLOTS);
        send_chan(1'b1, 24'h2468AC, SLOTS);
      end
      begin
        #(14 * 2 * HALF_BCLK + 20);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", smp.sample_valid, 0);
        check("mid_rst_left", smp.left_data, 0);
        check("mid_rst_right", smp.right_data, 0);
        check("mid_rst_mono", smp.mono_data, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_err_cnt", frame_err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    exp_q.push_back('{24'h300000, 24'h100000, 24'h200000});
    send_pair(24'h300000, 24'h100000);
    repeat (6) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_accepts", accepts, NVEC + 3);
    check("final_err_cnt", frame_err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
